// File: rtl/wb_stream_fifo.sv
// wb_stream_fifo: Wishbone slave queueing host words onto the lifting-datapath stream; ack/err one cycle after acceptance.
// Backpressure: DATA writes stall while full (WB_STREAM_FIFO_OVF_ERR_EN: accepted, dropped, err); i_busy holds o_data.

module sync_fifo #(
   parameter int AW = 4,
   parameter int DW = 32
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          flush,
   input  logic          wr_vld,
   input  logic [DW-1:0] wr_dat,
   input  logic          rd_rdy,
   output logic          rd_vld,
   output logic [DW-1:0] rd_dat,
   output logic [AW:0]   fill,
   output logic          full,
   output logic          empty
);
   localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_wr;
   logic          do_rd;

   assign do_wr  = wr_vld && !full;
   assign do_rd  = rd_rdy && !empty;
   assign full   = (fill == DEPTH);
   assign empty  = (fill == '0);
   assign rd_vld = !empty;
   assign rd_dat = mem[rd_ptr];

   always_ff @(posedge i_clk) begin
      if (do_wr) mem[wr_ptr] <= wr_dat;
   end

   // Flush wins over a same-cycle read so the popped word is simply discarded.
   always_ff @(posedge i_clk) begin
      if (i_rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill   <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   fill <= fill + 1'b1;
            2'b01:   fill <= fill - 1'b1;
            default: fill <= fill;
         endcase
      end
   end
endmodule

module wb_stream_fifo #(
   parameter int LGFLEN = 4,
   parameter int DW     = 32
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_wb_cyc,
   input  logic          i_wb_stb,
   input  logic          i_wb_we,
   input  logic [31:0]   i_wb_addr,
   input  logic [DW-1:0] i_wb_data,
   output logic          o_wb_ack,
   output logic          o_wb_stall,
   output logic          o_wb_err,
   output logic [DW-1:0] o_wb_data,
   output logic          o_stb,
   output logic [DW-1:0] o_data,
   input  logic          i_busy,
   output logic          o_int
);
   typedef struct packed {
      logic [15:0] fill;
      logic [12:0] rsvd;
      logic        ovf;
      logic        full;
      logic        empty;
   } status_t;

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_STATUS = 2'd1;
   localparam logic [1:0] ADDR_THRESH = 2'd2;
   localparam logic [1:0] ADDR_RSVD   = 2'd3;

   logic [1:0]      addr;
   logic            unused_addr;
   logic            is_data_wr;
   logic            accept;
   logic            ovf_drop;
   logic            err_req;
   logic            push;
   logic            pop;
   logic            flush;
   logic            status_wr;
   logic [LGFLEN:0] fill;
   logic [LGFLEN:0] thresh;
   logic            full;
   logic            empty;
   logic            ovf;
   logic            rd_vld;
   logic [DW-1:0]   rd_dat;
   status_t         status;

   assign addr        = i_wb_addr[1:0];
   assign unused_addr = ^i_wb_addr[31:2];
   assign is_data_wr  = i_wb_stb && i_wb_we && (addr == ADDR_DATA);

`ifdef WB_STREAM_FIFO_OVF_ERR_EN
   assign o_wb_stall = 1'b0;
   assign ovf_drop   = accept && is_data_wr && full;
`else
   assign o_wb_stall = full && is_data_wr;
   assign ovf_drop   = 1'b0;
`endif

   assign accept    = i_wb_cyc && i_wb_stb && !o_wb_stall;
   assign status_wr = accept && i_wb_we && (addr == ADDR_STATUS);
   assign push      = accept && is_data_wr && !full;
   assign flush     = status_wr && i_wb_data[1];
   assign pop       = o_stb && !i_busy;
   assign o_stb     = rd_vld;
   assign o_data    = o_stb ? rd_dat : '0;

   // DATA reads and the reserved slot answer with err instead of ack.
   always_comb begin
      err_req = 1'b0;
      if (accept) begin
         case (addr)
            ADDR_DATA: err_req = !i_wb_we || ovf_drop;
            ADDR_RSVD: err_req = 1'b1;
            default:   err_req = 1'b0;
         endcase
      end
   end

   always_comb begin
      status       = '0;
      status.fill  = 16'(fill);
      status.ovf   = ovf;
      status.full  = full;
      status.empty = empty;
   end

   sync_fifo #(
      .AW (LGFLEN),
      .DW (DW)
   ) u_fifo (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .flush  (flush),
      .wr_vld (push),
      .wr_dat (i_wb_data),
      .rd_rdy (pop),
      .rd_vld (rd_vld),
      .rd_dat (rd_dat),
      .fill   (fill),
      .full   (full),
      .empty  (empty)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_wb_ack  <= 1'b0;
         o_wb_err  <= 1'b0;
         o_wb_data <= '0;
         o_int     <= 1'b1;
         thresh    <= '0;
      end else begin
         o_wb_ack <= accept && !err_req;
         o_wb_err <= err_req;
         o_int    <= (fill <= thresh);
         if (accept && !i_wb_we) begin
            case (addr)
               ADDR_STATUS: o_wb_data <= status;
               ADDR_THRESH: o_wb_data <= DW'(thresh);
               default:     o_wb_data <= o_wb_data;
            endcase
         end
         if (accept && i_wb_we && (addr == ADDR_THRESH))
            thresh <= i_wb_data[LGFLEN:0];
      end
   end

`ifdef WB_STREAM_FIFO_OVF_ERR_EN
   always_ff @(posedge i_clk) begin
      if (i_rst)                         ovf <= 1'b0;
      else if (ovf_drop)                 ovf <= 1'b1;
      else if (status_wr && i_wb_data[0]) ovf <= 1'b0;
   end
`else
   assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_wb_stream_fifo.sv
// Randomised and directed bench for wb_stream_fifo against a queue-based model of the register map and stream.
module tb_wb_stream_fifo;
   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cyc = 1'b0;
   logic        stb = 1'b0;
   logic        we = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdat = '0;
   logic        busy = 1'b1;
   logic        o_wb_ack, o_wb_stall, o_wb_err, o_stb, o_int;
   logic [31:0] o_wb_data, o_data;

   int n_chk = 0;
   int n_fail = 0;

   wb_stream_fifo dut (
      .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
      .i_wb_addr(addr), .i_wb_data(wdat), .o_wb_ack(o_wb_ack), .o_wb_stall(o_wb_stall),
      .o_wb_err(o_wb_err), .o_wb_data(o_wb_data), .o_stb(o_stb), .o_data(o_data),
      .i_busy(busy), .o_int(o_int)
   );

   always #5 clk = ~clk;

   // Reference model state
   logic [31:0] q[$];
   logic [31:0] outs[$];
   int          mthr;
   bit          movf, mint, mack, merr, started;
   logic [31:0] mrd;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit exp_stall();
`ifdef WB_STREAM_FIFO_OVF_ERR_EN
      return 1'b0;
`else
      return (q.size() == DEPTH) && stb && we && (addr[1:0] == 2'd0);
`endif
   endfunction

   always @(posedge clk) begin
      int fill;
      bit full, acc, popd, flushed;
      if (rst) begin
         started = 1'b1;
         q.delete();
         mthr = 0; movf = 0; mint = 1; mack = 0; merr = 0; mrd = '0;
      end else if (started) begin
         fill    = q.size();
         full    = (fill == DEPTH);
         acc     = cyc && stb && !exp_stall();
         popd    = (fill != 0) && !busy;
         flushed = 1'b0;
         mint    = (fill <= mthr);
         mack    = 1'b0;
         merr    = 1'b0;
         if (acc) begin
            case (addr[1:0])
               2'd0: begin
                  if (!we) merr = 1'b1;
                  else if (full) begin merr = 1'b1; movf = 1'b1; end
                  else begin mack = 1'b1; q.push_back(wdat); end
               end
               2'd1: begin
                  mack = 1'b1;
                  if (we) begin
                     if (wdat[0]) movf = 1'b0;
                     if (wdat[1]) begin q.delete(); flushed = 1'b1; end
                  end else
                     mrd = (fill << 16) | (32'(movf) << 2) | (32'(full) << 1) | 32'(fill == 0);
               end
               2'd2: begin
                  mack = 1'b1;
                  if (we) mthr = int'(wdat[4:0]);
                  else mrd = 32'(mthr);
               end
               default: merr = 1'b1;
            endcase
         end
         if (popd && !flushed) begin
            outs.push_back(q[0]);
            void'(q.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("ack", 32'(o_wb_ack), 32'(mack));
         chk("err", 32'(o_wb_err), 32'(merr));
         chk("rdata", o_wb_data, mrd);
         chk("int", 32'(o_int), 32'(mint));
         chk("stall", 32'(o_wb_stall), 32'(exp_stall()));
         chk("stb", 32'(o_stb), 32'(q.size() != 0));
         if (q.size() != 0) chk("data", o_data, q[0]);
      end
   end

   logic [31:0] rd;
   bit          ga, ge;

   task automatic xfer(input bit w, input logic [1:0] a, input logic [31:0] d,
                       output logic [31:0] r, output bit ack, output bit err);
      int n;
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = w; addr = {30'($urandom), a}; wdat = d;
      n = 0;
      @(negedge clk);
      while (o_wb_stall && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) chk("xfer_timeout", 32'(n), 32'd0);
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0;
      @(negedge clk);
      r = o_wb_data; ack = o_wb_ack; err = o_wb_err;
   endtask

   task automatic rst_pulse();
      @(posedge clk); #1;
      rst = 1'b1; cyc = 1'b0; stb = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      outs.delete();
   endtask

   task automatic drain();
      int n;
      @(posedge clk); #1;
      busy = 1'b0;
      n = 0;
      @(negedge clk);
      while (o_stb && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) chk("drain_timeout", 32'(n), 32'd0);
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] a;
      int         sel, dead;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_int", 32'(o_int), 32'd1);
      chk("rst_stb", 32'(o_stb), 32'd0);
      chk("rst_data", o_data, 32'd0);
      xfer(1'b0, 2'd1, 32'd0, rd, ga, ge);
      chk("rst_status", rd, 32'h0000_0001);
      chk("rst_status_ack", 32'(ga), 32'd1);

      // Fill to full, then a DATA write must wait for one pop
      busy = 1'b1;
      outs.delete();
      for (int i = 0; i < 16; i++) xfer(1'b1, 2'd0, 32'h11 + 32'(i), rd, ga, ge);
      xfer(1'b0, 2'd1, 32'd0, rd, ga, ge);
      chk("full_status", rd, 32'h0010_0002);
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h100; wdat = 32'h21;
      repeat (3) begin @(negedge clk); chk("stall_hold", 32'(o_wb_stall), 32'd1); end
      @(posedge clk); #1 busy = 1'b0;
      @(negedge clk); chk("stall_pop_cycle", 32'(o_wb_stall), 32'd1);
      @(posedge clk); #1 busy = 1'b1;
      @(negedge clk); chk("stall_released", 32'(o_wb_stall), 32'd0);
      @(posedge clk); #1 cyc = 1'b0; stb = 1'b0;
      @(negedge clk); chk("stall_ack", 32'(o_wb_ack), 32'd1);
      drain();
      chk("order_cnt", 32'(outs.size()), 32'd17);
      for (int i = 0; i < 17 && i < outs.size(); i++)
         chk("order", outs[i], (i < 16) ? 32'h11 + 32'(i) : 32'h21);

      // Low-water interrupt
      rst_pulse();
      busy = 1'b1;
      xfer(1'b1, 2'd2, 32'd3, rd, ga, ge);
      for (int i = 0; i < 5; i++) xfer(1'b1, 2'd0, 32'h40 + 32'(i), rd, ga, ge);
      chk("int_low", 32'(o_int), 32'd0);
      @(posedge clk); #1 busy = 1'b0;
      repeat (3) @(negedge clk);
      chk("int_before", 32'(o_int), 32'd0);
      @(negedge clk);
      chk("int_after", 32'(o_int), 32'd1);
      drain();
      busy = 1'b1;

      // Error responses leave the FIFO alone
      xfer(1'b1, 2'd0, 32'hA1, rd, ga, ge);
      xfer(1'b1, 2'd0, 32'hA2, rd, ga, ge);
      xfer(1'b0, 2'd0, 32'd0, rd, ga, ge);
      chk("data_rd_err", 32'(ge), 32'd1);
      chk("data_rd_noack", 32'(ga), 32'd0);
      xfer(1'b1, 2'd3, 32'hFFFF_FFFF, rd, ga, ge);
      chk("rsvd_wr_err", 32'(ge), 32'd1);
      xfer(1'b0, 2'd3, 32'd0, rd, ga, ge);
      chk("rsvd_rd_err", 32'(ge), 32'd1);
      xfer(1'b0, 2'd1, 32'd0, rd, ga, ge);
      chk("err_status", rd, 32'h0002_0000);

      // Flush
      xfer(1'b1, 2'd0, 32'hA3, rd, ga, ge);
      xfer(1'b1, 2'd0, 32'hA4, rd, ga, ge);
      xfer(1'b1, 2'd1, 32'h2, rd, ga, ge);
      chk("flush_stb", 32'(o_stb), 32'd0);
      xfer(1'b0, 2'd1, 32'd0, rd, ga, ge);
      chk("flush_status", rd, 32'h0000_0001);
      xfer(1'b0, 2'd2, 32'd0, rd, ga, ge);
      chk("flush_thresh", rd, 32'd3);

`ifdef WB_STREAM_FIFO_OVF_ERR_EN
      rst_pulse();
      busy = 1'b1;
      for (int i = 0; i < 16; i++) xfer(1'b1, 2'd0, 32'h100 + 32'(i), rd, ga, ge);
      xfer(1'b1, 2'd0, 32'hDEAD, rd, ga, ge);
      chk("ovf_err", 32'(ge), 32'd1);
      chk("ovf_noack", 32'(ga), 32'd0);
      xfer(1'b0, 2'd1, 32'd0, rd, ga, ge);
      chk("ovf_status", rd, 32'h0010_0006);
      xfer(1'b1, 2'd1, 32'h1, rd, ga, ge);
      xfer(1'b0, 2'd1, 32'd0, rd, ga, ge);
      chk("ovf_cleared", rd, 32'h0010_0002);
      drain();
      dead = 0;
      foreach (outs[i]) if (outs[i] == 32'hDEAD) dead++;
      chk("ovf_dropped", 32'(dead), 32'd0);
      chk("ovf_cnt", 32'(outs.size()), 32'd16);
`endif

      // Random traffic: fill-biased first half, drain-biased second half
      for (int c = 0; c < 4000; c++) begin
         @(posedge clk); #1;
         rst  = ($urandom_range(0, 599) == 0);
         cyc  = ($urandom_range(0, 9) != 0);
         stb  = ($urandom_range(0, 2) != 0);
         we   = ($urandom_range(0, 3) != 0);
         sel  = $urandom_range(0, 9);
         a    = (sel < 6) ? 2'd0 : (sel < 8) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3;
         addr = {30'($urandom), a};
         wdat = $urandom;
         if (a == 2'd1 && $urandom_range(0, 15) != 0) wdat[1] = 1'b0;
         busy = (c < 2000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      end
      @(posedge clk); #1;
      rst = 1'b0; cyc = 1'b0; stb = 1'b0; busy = 1'b1;
      rst_pulse();
      xfer(1'b0, 2'd1, 32'd0, rd, ga, ge);
      chk("final_status", rd, 32'h0000_0001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/wb_stream_fifo.md
Name: wb_stream_fifo

Overview:
- Pipelined Wishbone slave that sits directly downstream of the DEPP-to-Wishbone bridge, on the bus it masters.
- Host writes through the DEPP bridge push 32-bit samples into an internal FIFO. The FIFO drains to a stream output that feeds the JPEG-2000 lifting datapath.
- Exposes status and threshold registers, plus a low-water interrupt that drives the bridge's i_int.

Parameters:
- LGFLEN, 4, log2 of FIFO depth (depth = 2**LGFLEN words); legal range 2..10.
- DW, 32, data width; fixed at 32 to match the bridge bus.

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_wb_cyc  in  1  Wishbone cycle.
- i_wb_stb  in  1  Wishbone strobe.
- i_wb_we  in  1  write enable.
- i_wb_addr  in  32  word address; only [1:0] decoded, upper bits ignored (base decode is external).
- i_wb_data  in  32  write data.
- o_wb_ack  out  1  acknowledge.
- o_wb_stall  out  1  stall.
- o_wb_err  out  1  bus error.
- o_wb_data  out  32  read data.
- o_stb  out  1  stream word valid.
- o_data  out  32  stream word.
- i_busy  in  1  downstream not ready.
- o_int  out  1  low-water interrupt.

Behaviour:
- Reset (i_rst=1 at an edge): o_wb_ack=0, o_wb_err=0, o_wb_stall=0, o_wb_data=0, o_stb=0, o_data=0, o_int=1. FIFO is emptied (pointers=0), overflow sticky=0, THRESH=0.
  - Reset mid-transaction drops any pending ack; the master must restart the cycle.
- Register map (i_wb_addr[1:0]):
  - 0 DATA: write pushes i_wb_data; read returns o_wb_err.
  - 1 STATUS: read {fill[15:0], 13'b0, ovf, full, empty}, where fill is zero-extended LGFLEN+1 bits. Write: bit0=1 clears ovf; bit1=1 flushes the FIFO.
  - 2 THRESH: R/W, low LGFLEN+1 bits significant; reads zero-extended.
  - 3 reserved: any access returns o_wb_err.
- Acceptance: a request is accepted when i_wb_stb && !o_wb_stall.
  - o_wb_ack or o_wb_err is asserted exactly one cycle after acceptance, never both, and each is 1 cycle wide.
  - One response per accepted strobe; back-to-back strobes get back-to-back acks.
- If i_wb_cyc=0, strobes are ignored and no ack/err is produced. A request accepted in cycle N is still acked in N+1 even if cyc drops.
- o_wb_data is valid in the ack cycle; otherwise it holds its last value.
- o_wb_stall = registered full && i_wb_stb && i_wb_we && addr==0. All other accesses are never stalled.
  - A pop in the same cycle does not release stall until the next cycle.
- FIFO and stream:
  - A pushed word is written at the acceptance edge.
  - o_stb rises no earlier than the ack cycle and stays high while the FIFO is non-empty.
  - Pop occurs when o_stb && !i_busy. o_data is stable while o_stb && i_busy.
  - Words are output in push order.
  - Pointers wrap modulo 2**LGFLEN; fill is tracked with LGFLEN+1 bits and counts from 0 to 2**LGFLEN.
- Simultaneous push and pop in one cycle: fill is unchanged and both take effect.
- Flush: takes effect at the edge ending the accepted write. Pointers and fill reset, and o_stb=0 next cycle. A pop in that same cycle is discarded. ovf and THRESH are not affected.
- Status updates: full = fill==2**LGFLEN; empty = fill==0. A STATUS read returns the value registered at the acceptance edge.
- o_int is registered: o_int = (fill <= THRESH), updated one cycle after any fill or THRESH change.

Optional Feature:
- Macro WB_STREAM_FIFO_OVF_ERR_EN.
- Defined: a DATA write while full is not stalled. It is accepted, the word is dropped, the FIFO is unchanged, o_wb_err is returned in place of ack, and the ovf sticky bit is set.
- Undefined: such writes are stalled as described above; ovf stays 0 and STATUS bit2 reads 0.

Test Plan:
- Reset, then read STATUS -> ack one cycle later, data 0x00000001; o_int=1, o_stb=0.
- LGFLEN=4, i_busy=1: push 0x11..0x1F (15 words), then 0x20 -> STATUS reads 0x00100002; next DATA write sees o_wb_stall=1 until i_busy drops for one pop, then it is accepted. Stream output order is 0x11..0x20 followed by the new word.
- Write THRESH=3, push 5 words with i_busy=1 -> o_int=0; release i_busy -> o_int returns to 1 one cycle after fill reaches 3.
- Read DATA and access addr 3 -> o_wb_err single-cycle pulse, no ack, FIFO unchanged.
- Push 4 words, write STATUS=0x2 -> next cycle o_stb=0 and STATUS reads 0x00000001; THRESH is preserved.
- With WB_STREAM_FIFO_OVF_ERR_EN: fill the FIFO, then write 0xDEAD -> o_wb_err=1 and STATUS bit2=1; write STATUS=0x1 -> bit2 clears. 0xDEAD never appears on o_data.
